// File: rtl/rv32_dec_pkg.sv
// rv32_dec_pkg: shared RV32I decode encodings (opcodes, class bits, ImmSel, ALUOp) and the decoded bundle
package rv32_dec_pkg;
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_FENCE  = 5'b00011;
  localparam logic [4:0] OP_IMM    = 5'b00100;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_OP     = 5'b01100;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_SYSTEM = 5'b11100;
  localparam int C_R     = 0;
  localparam int C_IL    = 1;
  localparam int C_IC    = 2;
  localparam int C_JALR  = 3;
  localparam int C_S     = 4;
  localparam int C_B     = 5;
  localparam int C_LUI   = 6;
  localparam int C_AUIPC = 7;
  localparam int C_JAL   = 8;
  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_sel_e;
  typedef enum logic [1:0] {ALU_ADD, ALU_R, ALU_PASSB, ALU_I} alu_op_e;
  typedef struct packed {
    logic [8:0]  cls;
    imm_sel_e    sel;
    alu_op_e     alu;
    logic        is_mul;
    logic        is_sys;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [31:0] imm;
    logic        illegal;
  } dec_t;
endpackage

// File: rtl/decode_stage_if.sv
// decode_stage_if: upstream valid/ready instruction channel and downstream decoded-bundle channel
interface decode_stage_if #(parameter int PC_W = 32, parameter int CNT_W = 16);
  logic            in_valid, in_ready, flush;
  logic [31:0]     in_instr;
  logic [PC_W-1:0] in_pc;
  logic            out_valid, out_ready;
  logic [8:0]      out_class;
  logic [2:0]      out_imm_sel, out_funct3;
  logic [1:0]      out_alu_op;
  logic            out_is_mul, out_is_sys, out_illegal;
  logic [4:0]      out_rd, out_rs1, out_rs2;
  logic [31:0]     out_imm;
  logic [PC_W-1:0] out_pc;
  logic [CNT_W-1:0] illegal_cnt;
  modport master(output in_valid, in_instr, in_pc, flush, out_ready,
                 input in_ready, out_valid, out_class, out_imm_sel, out_alu_op, out_is_mul, out_is_sys,
                 out_rd, out_rs1, out_rs2, out_funct3, out_imm, out_pc, out_illegal, illegal_cnt);
  modport slave(input in_valid, in_instr, in_pc, flush, out_ready,
                output in_ready, out_valid, out_class, out_imm_sel, out_alu_op, out_is_mul, out_is_sys,
                out_rd, out_rs1, out_rs2, out_funct3, out_imm, out_pc, out_illegal, illegal_cnt);
endinterface

// File: rtl/decode_stage_imm_gen.sv
// imm_gen: sign-extended RV32I immediate for the selected format
module imm_gen
  import rv32_dec_pkg::*;
(
  input  logic [31:7] ins,
  input  imm_sel_e    sel,
  output logic [31:0] imm
);
  // pick the bit scatter of the selected format
  always_comb
    imm = sel == IMM_I ? {{20{ins[31]}}, ins[31:20]} :
          sel == IMM_S ? {{20{ins[31]}}, ins[31:25], ins[11:7]} :
          sel == IMM_B ? {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0} :
          sel == IMM_U ? {ins[31:12], 12'b0} :
          sel == IMM_J ? {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0} : '0;
endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered RV32I decode with valid/ready handshake, flush and saturating illegal counter
module decode_stage
  import rv32_dec_pkg::*;
#(
  parameter int PC_W   = 32,
  parameter bit EN_M   = 1'b0,
  parameter bit EN_SYS = 1'b0,
  parameter int CNT_W  = 16
) (
  input logic clk,
  input logic rst,
  decode_stage_if.slave bus
);
  logic [4:0]       op;
  logic [2:0]       f3;
  logic [6:0]       f7;
  logic [8:0]       cls;
  logic             sys, bad, v;
  imm_sel_e         sel;
  alu_op_e          alu;
  logic [31:0]      imm_raw;
  dec_t             d, q;
  logic [PC_W-1:0]  pc_q;
  logic [CNT_W-1:0] cnt;
  assign op = bus.in_instr[6:2];
  assign f3 = bus.in_instr[14:12];
  assign f7 = bus.in_instr[31:25];
  imm_gen u_imm (.ins(bus.in_instr[31:7]), .sel(sel), .imm(imm_raw));
  // class, codes and legality of the incoming word; illegal words collapse to an all-zero control bundle
  always_comb begin
    cls = '0;
    cls[C_R]     = op == OP_OP;
    cls[C_IL]    = op == OP_LOAD;
    cls[C_IC]    = op == OP_IMM;
    cls[C_JALR]  = op == OP_JALR;
    cls[C_S]     = op == OP_STORE;
    cls[C_B]     = op == OP_BRANCH;
    cls[C_LUI]   = op == OP_LUI;
    cls[C_AUIPC] = op == OP_AUIPC;
    cls[C_JAL]   = op == OP_JAL;
    sys = EN_SYS && (op == OP_FENCE || op == OP_SYSTEM);
    bad = bus.in_instr[1:0] != 2'b11 || !(|cls || sys)
       || (cls[C_JALR] && f3 != 3'd0)
       || (cls[C_B] && f3[2:1] == 2'b01)
       || (cls[C_IL] && (f3 == 3'd3 || f3[2:1] == 2'b11))
       || (cls[C_S] && f3 > 3'd2)
       || (cls[C_R] && !(f7 == 7'b0000000 || (f7 == 7'b0100000 && (f3 == 3'd0 || f3 == 3'd5))
                         || (f7 == 7'b0000001 && EN_M)))
       || (cls[C_IC] && f3[1:0] == 2'b01 && !(f7 == 7'b0000000 || (f7 == 7'b0100000 && f3[2])));
    sel = cls[C_S] ? IMM_S : cls[C_B] ? IMM_B : (cls[C_LUI] || cls[C_AUIPC]) ? IMM_U : cls[C_JAL] ? IMM_J : IMM_I;
    alu = cls[C_R] ? ALU_R : cls[C_IC] ? ALU_I : cls[C_LUI] ? ALU_PASSB : ALU_ADD;
    d.cls     = bad ? '0 : cls;
    d.sel     = bad ? IMM_I : sel;
    d.alu     = bad ? ALU_ADD : alu;
    d.is_mul  = !bad && cls[C_R] && f7 == 7'b0000001;
    d.is_sys  = !bad && sys;
    d.rd      = bus.in_instr[11:7];
    d.rs1     = bus.in_instr[19:15];
    d.rs2     = bus.in_instr[24:20];
    d.funct3  = f3;
    d.imm     = (bad || cls[C_R]) ? '0 : imm_raw;
    d.illegal = bad;
  end
  assign bus.in_ready = !bus.flush && (!v || bus.out_ready);
  // output register: reset beats flush, flush beats accept, accept beats drain
  always_ff @(posedge clk) begin
    if (rst) begin
      v    <= 1'b0;
      q    <= '0;
      pc_q <= '0;
    end else if (bus.flush) begin
      v <= 1'b0;
    end else if (bus.in_valid && bus.in_ready) begin
      v    <= 1'b1;
      q    <= d;
      pc_q <= bus.in_pc;
    end else if (bus.out_ready) begin
      v <= 1'b0;
    end
  end
  // count illegal bundles actually taken downstream, saturating at all-ones
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (v && bus.out_ready && !bus.flush && q.illegal && !(&cnt)) cnt <= cnt + 1'b1;
  end
  assign bus.out_valid   = v;
  assign bus.out_class   = q.cls;
  assign bus.out_imm_sel = q.sel;
  assign bus.out_alu_op  = q.alu;
  assign bus.out_is_mul  = q.is_mul;
  assign bus.out_is_sys  = q.is_sys;
  assign bus.out_rd      = q.rd;
  assign bus.out_rs1     = q.rs1;
  assign bus.out_rs2     = q.rs2;
  assign bus.out_funct3  = q.funct3;
  assign bus.out_imm     = q.imm;
  assign bus.out_pc      = pc_q;
  assign bus.out_illegal = q.illegal;
  assign bus.illegal_cnt = cnt;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: two decode_stage configurations driven in lockstep against a behavioural reference
module tb_decode_stage;
  typedef struct {
    logic [8:0]  cls;
    logic [2:0]  sel;
    logic [1:0]  alu;
    logic        mul, sys, ill;
    logic [31:0] imm;
  } ref_t;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [31:0] in_instr = '0, in_pc = '0;
  always #5 clk = ~clk;
  decode_stage_if #(.PC_W(32), .CNT_W(16)) i0();
  decode_stage_if #(.PC_W(32), .CNT_W(2))  i1();
  assign i0.in_valid = in_valid;
  assign i0.in_instr = in_instr;
  assign i0.in_pc = in_pc;
  assign i0.flush = flush;
  assign i0.out_ready = out_ready;
  assign i1.in_valid = in_valid;
  assign i1.in_instr = in_instr;
  assign i1.in_pc = in_pc;
  assign i1.flush = flush;
  assign i1.out_ready = out_ready;
  decode_stage #(.PC_W(32), .EN_M(1'b0), .EN_SYS(1'b0), .CNT_W(16)) u0 (.clk(clk), .rst(rst), .bus(i0));
  decode_stage #(.PC_W(32), .EN_M(1'b1), .EN_SYS(1'b1), .CNT_W(2))  u1 (.clk(clk), .rst(rst), .bus(i1));
  int errs = 0, checks = 0;
  bit mv = 0;
  ref_t e0, e1;
  logic [31:0] ew = '0, epc = '0;
  int c0 = 0, c1 = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic ref_t zero_ref();
    ref_t r;
    r.cls = '0; r.sel = '0; r.alu = '0; r.mul = 0; r.sys = 0; r.ill = 0; r.imm = '0;
    return r;
  endfunction
  function automatic ref_t refd(input logic [31:0] w, input bit em, input bit es);
    ref_t r;
    logic signed [31:0] sw;
    logic [31:0] s20, s19, s11;
    logic [2:0] f3;
    logic [6:0] f7;
    bit ok;
    int idx;
    r = zero_ref();
    sw = w; s20 = sw >>> 20; s19 = sw >>> 19; s11 = sw >>> 11;
    f3 = w[14:12]; f7 = w[31:25]; ok = 0; idx = -1;
    case (w[6:0])
      7'h33: begin idx = 0; r.alu = 2'b01; r.mul = f7 == 7'h01;
                   ok = f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) || (f7 == 7'h01 && em); end
      7'h03: begin idx = 1; ok = !(f3 inside {3'd3, 3'd6, 3'd7}); end
      7'h13: begin idx = 2; r.alu = 2'b11;
                   ok = f3 == 3'd1 ? f7 == 7'h00 : f3 == 3'd5 ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1; end
      7'h67: begin idx = 3; ok = f3 == 3'd0; end
      7'h23: begin idx = 4; r.sel = 3'd1; ok = f3 <= 3'd2; end
      7'h63: begin idx = 5; r.sel = 3'd2; ok = !(f3 inside {3'd2, 3'd3}); end
      7'h37: begin idx = 6; r.sel = 3'd3; r.alu = 2'b10; ok = 1; end
      7'h17: begin idx = 7; r.sel = 3'd3; ok = 1; end
      7'h6F: begin idx = 8; r.sel = 3'd4; ok = 1; end
      7'h0F, 7'h73: begin r.sys = 1; ok = es; end
      default: ok = 0;
    endcase
    if (!ok) begin
      r = zero_ref();
      r.ill = 1;
      return r;
    end
    if (idx >= 0) r.cls = 9'(1) << idx;
    case (r.sel)
      3'd0: r.imm = s20;
      3'd1: r.imm = (s20 & ~32'h1F) | 32'(w[11:7]);
      3'd2: r.imm = (s19 & 32'hFFFFF000) | (32'(w[7]) << 11) | (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
      3'd3: r.imm = w & 32'hFFFFF000;
      default: r.imm = (s11 & 32'hFFF00000) | (w & 32'h000FF000) | (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
    endcase
    if (idx == 0) r.imm = '0;
    return r;
  endfunction
  function automatic logic [31:0] rnd_instr();
    logic [31:0] w;
    logic [6:0] ops [12];
    ops = '{7'h33, 7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h0F, 7'h73, 7'h13};
    w = $urandom;
    if ($urandom_range(0, 9) != 0) w[6:0] = ops[$urandom_range(0, 11)];
    case ($urandom_range(0, 3))
      0: w[31:25] = 7'h00;
      1: w[31:25] = 7'h20;
      2: w[31:25] = 7'h01;
      default: ;
    endcase
    return w;
  endfunction
  task automatic model_edge();
    bit rdy, take;
    rdy = !flush && (!mv || out_ready);
    take = mv && out_ready && !flush;
    if (rst) begin
      mv = 0; e0 = zero_ref(); e1 = zero_ref(); ew = '0; epc = '0; c0 = 0; c1 = 0;
      return;
    end
    if (take && e0.ill && c0 < 65535) c0++;
    if (take && e1.ill && c1 < 3) c1++;
    if (flush) mv = 0;
    else if (in_valid && rdy) begin
      mv = 1; e0 = refd(in_instr, 0, 0); e1 = refd(in_instr, 1, 1); ew = in_instr; epc = in_pc;
    end else if (out_ready) mv = 0;
  endtask
  task automatic check_outs();
    logic [19:0] regs;
    regs = {ew[11:7], ew[19:15], ew[24:20], ew[14:12]};
    chk("d0_valid", i0.out_valid, mv);
    chk("d0_class", i0.out_class, e0.cls);
    chk("d0_ctl", {i0.out_imm_sel, i0.out_alu_op, i0.out_is_mul, i0.out_is_sys, i0.out_illegal},
        {e0.sel, e0.alu, e0.mul, e0.sys, e0.ill});
    chk("d0_regs", {i0.out_rd, i0.out_rs1, i0.out_rs2, i0.out_funct3}, regs);
    chk("d0_imm", i0.out_imm, e0.imm);
    chk("d0_pc", i0.out_pc, epc);
    chk("d0_cnt", i0.illegal_cnt, c0);
    chk("d1_valid", i1.out_valid, mv);
    chk("d1_class", i1.out_class, e1.cls);
    chk("d1_ctl", {i1.out_imm_sel, i1.out_alu_op, i1.out_is_mul, i1.out_is_sys, i1.out_illegal},
        {e1.sel, e1.alu, e1.mul, e1.sys, e1.ill});
    chk("d1_regs", {i1.out_rd, i1.out_rs1, i1.out_rs2, i1.out_funct3}, regs);
    chk("d1_imm", i1.out_imm, e1.imm);
    chk("d1_pc", i1.out_pc, epc);
    chk("d1_cnt", i1.illegal_cnt, c1);
  endtask
  task automatic cyc();
    @(negedge clk);
    chk("d0_in_ready", i0.in_ready, !flush && (!mv || out_ready));
    chk("d1_in_ready", i1.in_ready, !flush && (!mv || out_ready));
    @(posedge clk);
    model_edge();
    #1;
    check_outs();
  endtask
  task automatic drive(input logic [31:0] w);
    in_valid = 1'b1;
    in_instr = w;
    in_pc = $urandom;
  endtask
  initial begin
    e0 = zero_ref();
    e1 = zero_ref();
    @(posedge clk);
    #1;
    cyc();
    rst = 1'b0;
    cyc();
    chk("rst_ready", i0.in_ready, 1'b1);
    out_ready = 1'b1;
    drive(32'h00500093);
    cyc();
    in_valid = 1'b0;
    chk("addi_class", i0.out_class, 9'h004);
    chk("addi_ctl", {i0.out_imm_sel, i0.out_alu_op, i0.out_rd, i0.out_illegal}, {3'd0, 2'b11, 5'd1, 1'b0});
    chk("addi_imm", i0.out_imm, 32'h00000005);
    drive(32'h12345137);
    cyc();
    chk("lui_imm", i0.out_imm, 32'h12345000);
    chk("lui_alu", i0.out_alu_op, 2'b10);
    drive(32'hFE000EE3);
    cyc();
    chk("beq_sel", i0.out_imm_sel, 3'd2);
    chk("beq_imm", i0.out_imm, 32'hFFFFFFFC);
    chk("beq_valid", i0.out_valid, 1'b1);
    in_valid = 1'b0;
    cyc();
    drive(32'h022081B3);
    cyc();
    in_valid = 1'b0;
    chk("mul0_ill", {i0.out_illegal, i0.out_class}, {1'b1, 9'h000});
    chk("mul1_dec", {i1.out_class, i1.out_is_mul, i1.out_illegal}, {9'h001, 1'b1, 1'b0});
    cyc();
    chk("mul0_cnt", i0.illegal_cnt, 16'd1);
    chk("mul1_cnt", i1.illegal_cnt, 2'd0);
    out_ready = 1'b0;
    drive(32'h00500093);
    cyc();
    drive(32'h12345137);
    repeat (3) cyc();
    chk("bp_ready", i0.in_ready, 1'b0);
    chk("bp_imm", i0.out_imm, 32'h00000005);
    out_ready = 1'b1;
    cyc();
    chk("swap_valid", i0.out_valid, 1'b1);
    chk("swap_imm", i0.out_imm, 32'h12345000);
    out_ready = 1'b0;
    drive(32'hFE000EE3);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", i0.out_valid, 1'b0);
    chk("flush_cnt", i0.illegal_cnt, 16'd1);
    drive(32'hFFFFFFFF);
    cyc();
    in_valid = 1'b0;
    chk("ill_held", i0.out_illegal, 1'b1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rst_valid", i0.out_valid, 1'b0);
    chk("rst_cnt", i0.illegal_cnt, 16'd0);
    out_ready = 1'b1;
    drive(32'hFFFFFFFF);
    repeat (6) cyc();
    in_valid = 1'b0;
    cyc();
    chk("sat_cnt1", i1.illegal_cnt, 2'd3);
    chk("sat_cnt0", i0.illegal_cnt, 16'd6);
    repeat (3000) begin
      rst = $urandom_range(0, 99) == 0;
      flush = $urandom_range(0, 7) == 0;
      out_ready = $urandom_range(0, 2) != 0;
      in_valid = $urandom_range(0, 3) != 0;
      in_instr = rnd_instr();
      in_pc = $urandom;
      cyc();
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
# decode_stage

Registered RV32I decode stage that extends the combinational main decoder into a pipelined, handshaked block. It accepts one 32-bit instruction word and its PC per cycle over a valid/ready interface. It produces the instruction class, immediate-select code, ALU op code, register fields, the sign-extended immediate and an illegal-instruction flag one cycle later. It sits between the fetch buffer and the register-read/execute stage, and its class/ImmSel/ALUOp encodings match the existing main decoder.

## Interface
- PC_W, 32: width of the PC carried alongside the instruction.
- EN_M, 0: 1 = accept RV32M (funct7 = 0000001 on OP) as a legal R-type with `is_mul` set.
- EN_SYS, 0: 1 = accept FENCE (opcode 0001111) and SYSTEM (1110011) as legal with `is_sys` set.
- CNT_W, 16: width of the saturating illegal-instruction counter.

Ports:
- clk  in  1  the only clock.
- rst  in  1  reset, synchronous and active-high.
- in_valid  in  1  instruction word valid.
- in_ready  out  1  stage can accept an instruction this cycle.
- in_instr  in  32  instruction word.
- in_pc  in  PC_W  instruction PC.
- flush  in  1  discard the held output and block acceptance this cycle.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  downstream accepts the bundle.
- out_class  out  9  one-hot: {JAL, AUIPC, LUI, B, S, JALR, I_C, I_L, R} (bit 0 = R).
- out_imm_sel  out  3  0 I, 1 S, 2 B, 3 U, 4 J.
- out_alu_op  out  2  00 add, 01 R funct, 10 pass-B, 11 I funct.
- out_is_mul, out_is_sys  out  1 each.
- out_rd, out_rs1, out_rs2  out  5 each.
- out_funct3  out  3.
- out_imm  out  32  sign-extended immediate per imm_sel; 0 for R-type.
- out_pc  out  PC_W.
- out_illegal  out  1.
- illegal_cnt  out  CNT_W  saturating count of illegal bundles accepted by downstream.

## Operation
- Accept condition: `in_valid && in_ready`. Ready rule: `in_ready = !flush && (!out_valid || out_ready)`.
- On accept, the combinational decode of `in_instr` is captured into the output register and `out_valid` is set.
- On `out_valid && out_ready` with no new accept, `out_valid` clears.
- Class and code rules follow the main decoder truth table over opcode[6:2]. ALUOp is 01 for R, 11 for I_C, 10 for LUI, and 00 otherwise.
- An instruction is illegal when any of these holds:
  - opcode[1:0] != 11;
  - the opcode is not in the supported set (FENCE/SYSTEM count only when EN_SYS = 1);
  - JALR with funct3 != 000;
  - B with funct3 = 010 or 011;
  - a load with funct3 of 011, 110 or 111;
  - a store with funct3 > 010;
  - R with funct7 other than 0000000, 0100000 (only with funct3 000 or 101), or 0000001 (only with EN_M = 1);
  - an I shift (funct3 001/101) with funct7 other than 0000000, or other than 0100000 when funct3 = 101.
- For an illegal instruction: `out_class = 0`, `imm_sel = 0`, `alu_op = 00`, `is_mul = is_sys = 0`, `imm = 0`, `illegal = 1`. The register fields and PC still pass through.
- `illegal_cnt` increments by 1 on each `out_valid && out_ready && out_illegal`. It holds at all-ones once saturated.
- `flush` clears `out_valid` next edge, even if `out_ready` is low. During a flush cycle no input is accepted, and a flushed bundle is not counted.

## Timing
- Latency is 1 cycle from accept to `out_valid`. Throughput is 1 per cycle while `out_ready` is high.
- While `out_valid && !out_ready`, every `out_*` field is held stable.
- Reset: `out_valid = 0`, all `out_*` data = 0, `illegal_cnt = 0`, `in_ready = 1` (with flush low) from the first cycle after reset.
- Reset mid-transfer drops the held bundle without counting it.
- Reset has priority over flush, and flush has priority over accept and hold.
- When an accept and a downstream take happen in the same cycle, the new bundle replaces the old one with no bubble. A take of an illegal bundle still counts in that cycle.

## Structure
- Shared package `rv32_dec_pkg`: the opcode constants, the class bit indices, the ImmSel codes (0 to 4) and the ALUOp codes. The existing main decoder is to be moved onto these as well.
- One sub-module, `imm_gen`: combinational, taking instr[31:7] and imm_sel and producing the 32-bit immediate.
- The decode and illegal check stay inline in `decode_stage`.

## Test plan
- `0x00500093` (addi x1,x0,5) accepted → next cycle: class I_C, imm_sel 0, alu_op 11, rd 1, imm 0x00000005, illegal 0.
- `0x12345137` (lui x2,0x12345) followed back-to-back by `0xFE000EE3` (beq x0,x0,-4), `out_ready` high → LUI with imm 0x12345000 and alu_op 10, then B with imm_sel 2 and imm 0xFFFFFFFC, on consecutive cycles.
- `0x022081B3` (mul x3,x1,x2):
  - with EN_M = 0 → illegal 1, class 0, `illegal_cnt` increments to 1 on the take;
  - with EN_M = 1 → class R, is_mul 1, illegal 0, count unchanged.
- Backpressure: hold `out_ready` low for 3 cycles with a bundle held → `in_ready` is 0 and `out_*` is stable. Raise `out_ready` with a new `in_valid` present → the swap happens with no bubble.
- Flush with `out_valid` = 1, `out_ready` = 0 and `in_valid` = 1 → `in_ready` is 0, `out_valid` is 0 next cycle, the input is not consumed and the count is unchanged.
- Assert rst while an illegal bundle is held → `out_valid` 0, `illegal_cnt` 0. Force the counter to saturate with CNT_W = 2 → it reads 3 after 4 or more illegal takes.
